cpu_sequencer: RTL and testbench

- Control unit for the 8-bit sysbus CPU: 3-bit opcode plus 5-bit address.
- Generates every bus-drive and register-load strobe for PC, IR, ACC, MAR/MDR, the ROM and the RAM.
- Runs a fetch / decode / execute FSM, with a programmable wait-state counter on every memory access.
- Sits beside the datapath. Inputs are only the IR opcode field and the accumulator zero flag.

---
 rtl/cpu_pkg.sv | 42 ++++
 rtl/seq_wait_counter.sv | 33 +++
 rtl/cpu_sequencer.sv | 144 ++++++++++++++
 tb/tb_cpu_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the sysbus CPU sequencer: opcodes, FSM states, ALU selects.
package cpu_pkg;

    localparam int unsigned CPU_WORD_W = 8;
    localparam int unsigned CPU_OP_W   = 3;

    typedef enum logic [2:0] {
        OP_LOAD  = 3'b000,
        OP_STORE = 3'b001,
        OP_ADD   = 3'b010,
        OP_SUB   = 3'b011,
        OP_XOR   = 3'b100,
        OP_BNE   = 3'b101,
        OP_BRA   = 3'b110,
        OP_HALT  = 3'b111
    } opcode_t;

    typedef enum logic [2:0] {
        S_IFETCH,
        S_IREAD,
        S_DECODE,
        S_EXEC,
        S_HALT
    } state_t;

    typedef enum logic [1:0] {
        ALU_PASS = 2'b00,
        ALU_ADD  = 2'b01,
        ALU_SUB  = 2'b10,
        ALU_XOR  = 2'b11
    } alu_op_t;

    function automatic alu_op_t alu_of(input opcode_t op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_XOR:  return ALU_XOR;
            default: return ALU_PASS;
        endcase
    endfunction

endpackage

// File: rtl/seq_wait_counter.sv
// Memory wait-state counter; done while the held count equals the limit.
module seq_wait_counter (
    input  logic       clock,
    input  logic       n_reset,
    input  logic       clear,
    input  logic       enable,
    input  logic [3:0] limit,
    output logic       done
);

    logic [3:0] count_q;
    logic [3:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 4'd1;
        end
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == limit);

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute control unit for the 8-bit sysbus CPU.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned WORD_W   = CPU_WORD_W,
    parameter int unsigned OP_W     = CPU_OP_W,
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic            clock,
    input  logic            n_reset,
    input  logic [OP_W-1:0] opcode,
    input  logic            z_flag,
    output logic            PC_bus,
    output logic            load_PC,
    output logic            INC_PC,
    output logic            load_IR,
    output logic            Addr_bus,
    output logic            load_MAR,
    output logic            MDR_bus,
    output logic            load_MDR,
    output logic            CS,
    output logic            R_NW,
    output logic            ACC_bus,
    output logic            load_ACC,
    output logic [1:0]      alu_op,
    output logic            halted
);

    if (WORD_W <= OP_W || OP_W != 3 || MEM_WAIT > 15) begin : g_bad_params
        $error("cpu_sequencer: unsupported WORD_W/OP_W/MEM_WAIT combination");
    end

    state_t  state_q;
    state_t  state_d;
    opcode_t op;
    logic    held;
    logic    wait_done;

    assign op   = opcode_t'(opcode);
    assign held = (state_q == S_IREAD) || (state_q == S_EXEC);

    // Clearing on the exiting cycle leaves the count at zero on every entry.
    seq_wait_counter u_wait (
        .clock   (clock),
        .n_reset (n_reset),
        .clear   (held && wait_done),
        .enable  (held && !wait_done),
        .limit   (4'(MEM_WAIT)),
        .done    (wait_done)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IFETCH: state_d = S_IREAD;
            S_IREAD:  if (wait_done) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_BRA, OP_BNE: state_d = S_IFETCH;
                    OP_HALT:        state_d = S_HALT;
                    default:        state_d = S_EXEC;
                endcase
            end
            S_EXEC:   if (wait_done) state_d = S_IFETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IFETCH;
        endcase
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= S_IFETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Strobes are gated by n_reset so an asserted reset silences them instantly.
    always_comb begin
        PC_bus   = 1'b0;
        load_PC  = 1'b0;
        INC_PC   = 1'b0;
        load_IR  = 1'b0;
        Addr_bus = 1'b0;
        load_MAR = 1'b0;
        MDR_bus  = 1'b0;
        load_MDR = 1'b0;
        CS       = 1'b0;
        R_NW     = 1'b1;
        ACC_bus  = 1'b0;
        load_ACC = 1'b0;
        alu_op   = ALU_PASS;
        halted   = 1'b0;
        if (n_reset) begin
            unique case (state_q)
                S_IFETCH: begin
                    PC_bus   = 1'b1;
                    load_MAR = 1'b1;
                    INC_PC   = 1'b1;
                end
                S_IREAD: begin
                    CS      = 1'b1;
                    MDR_bus = 1'b1;
                    load_IR = wait_done;
                end
                S_DECODE: begin
                    case (op)
                        OP_BRA: begin
                            Addr_bus = 1'b1;
                            load_PC  = 1'b1;
                        end
                        OP_BNE: begin
                            Addr_bus = !z_flag;
                            load_PC  = !z_flag;
                        end
                        OP_HALT: ;
                        default: begin
                            Addr_bus = 1'b1;
                            load_MAR = 1'b1;
                        end
                    endcase
                end
                S_EXEC: begin
                    CS = 1'b1;
                    if (op == OP_STORE) begin
                        ACC_bus  = 1'b1;
                        load_MDR = 1'b1;
                        R_NW     = 1'b0;
                    end else begin
                        MDR_bus  = 1'b1;
                        alu_op   = alu_of(op);
                        load_ACC = wait_done;
                    end
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

    bus_exclusive: assert property (@(posedge clock)
        $onehot0({PC_bus, Addr_bus, MDR_bus, ACC_bus}));

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: three instances (MEM_WAIT 0/2/3) share stimulus.
module tb_cpu_sequencer;
    import cpu_pkg::*;

    logic       clock   = 1'b0;
    logic       n_reset = 1'b0;
    logic [2:0] opcode  = 3'b000;
    logic       z_flag  = 1'b0;

    always #5 clock = ~clock;

    // Vector layout: PC_bus load_PC INC_PC load_IR Addr_bus load_MAR MDR_bus
    //                load_MDR CS R_NW ACC_bus load_ACC alu_op[1:0] halted
    localparam logic [14:0] M_PCB  = 15'h4000;
    localparam logic [14:0] M_LPC  = 15'h2000;
    localparam logic [14:0] M_INC  = 15'h1000;
    localparam logic [14:0] M_LIR  = 15'h0800;
    localparam logic [14:0] M_ADB  = 15'h0400;
    localparam logic [14:0] M_LMAR = 15'h0200;
    localparam logic [14:0] M_MDRB = 15'h0100;
    localparam logic [14:0] M_LMDR = 15'h0080;
    localparam logic [14:0] M_CS   = 15'h0040;
    localparam logic [14:0] M_RNW  = 15'h0020;
    localparam logic [14:0] M_ACCB = 15'h0010;
    localparam logic [14:0] M_LACC = 15'h0008;
    localparam logic [14:0] M_HLT  = 15'h0001;
    localparam logic [14:0] V_DEF    = M_RNW;
    localparam logic [14:0] V_IFETCH = M_PCB | M_LMAR | M_INC | M_RNW;

    logic [14:0] act [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic       pc_bus, load_pc, inc_pc, load_ir, addr_bus, load_mar, mdr_bus;
        logic       load_mdr, cs, r_nw, acc_bus, load_acc, halted;
        logic [1:0] alu_op;

        cpu_sequencer #(
            .WORD_W   (8),
            .OP_W     (3),
            .MEM_WAIT (g == 0 ? 0 : (g == 1 ? 2 : 3))
        ) dut (
            .clock    (clock),
            .n_reset  (n_reset),
            .opcode   (opcode),
            .z_flag   (z_flag),
            .PC_bus   (pc_bus),
            .load_PC  (load_pc),
            .INC_PC   (inc_pc),
            .load_IR  (load_ir),
            .Addr_bus (addr_bus),
            .load_MAR (load_mar),
            .MDR_bus  (mdr_bus),
            .load_MDR (load_mdr),
            .CS       (cs),
            .R_NW     (r_nw),
            .ACC_bus  (acc_bus),
            .load_ACC (load_acc),
            .alu_op   (alu_op),
            .halted   (halted)
        );

        assign act[g] = {pc_bus, load_pc, inc_pc, load_ir, addr_bus, load_mar, mdr_bus,
                         load_mdr, cs, r_nw, acc_bus, load_acc, alu_op, halted};
    end

    typedef struct {
        logic [14:0] v;
        int          scen;
        int          idx;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    int   checks   = 0;
    int   failures = 0;
    int   scen     = 0;
    int   pcnt [3];

    function automatic int unsigned mw_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
    endfunction

    function automatic void check(input int d, input string what, input logic [14:0] got,
                                  input logic [14:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s dut%0d (MEM_WAIT=%0d) got=%h want=%h", what, d, mw_of(d), got, want);
        end
    endfunction

    function automatic void push(input int d, input logic [14:0] v);
        exp_t e;
        e.v = v;
        e.scen = scen;
        e.idx = pcnt[d];
        pcnt[d]++;
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic void push_instr(input int d, input opcode_t op, input logic z);
        logic [14:0] ex;
        push(d, V_IFETCH);
        for (int unsigned k = 0; k <= mw_of(d); k++)
            push(d, M_CS | M_MDRB | M_RNW | ((k == mw_of(d)) ? M_LIR : 15'h0));
        case (op)
            OP_BRA:  push(d, M_ADB | M_LPC | M_RNW);
            OP_BNE:  push(d, z ? V_DEF : (M_ADB | M_LPC | M_RNW));
            OP_HALT: begin
                push(d, V_DEF);
                for (int unsigned k = 0; k < 20; k++) push(d, M_RNW | M_HLT);
            end
            default: begin
                push(d, M_ADB | M_LMAR | M_RNW);
                for (int unsigned k = 0; k <= mw_of(d); k++) begin
                    case (op)
                        OP_STORE: ex = M_ACCB | M_LMDR | M_CS;
                        OP_ADD:   ex = M_CS | M_MDRB | M_RNW | 15'h0002;
                        OP_SUB:   ex = M_CS | M_MDRB | M_RNW | 15'h0004;
                        OP_XOR:   ex = M_CS | M_MDRB | M_RNW | 15'h0006;
                        default:  ex = M_CS | M_MDRB | M_RNW;
                    endcase
                    if (op != OP_STORE && k == mw_of(d)) ex = ex | M_LACC;
                    push(d, ex);
                end
            end
        endcase
    endfunction

    // Monitor: every cycle each instance with a pending expectation is compared.
    always @(negedge clock) begin
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            check(0, $sformatf("scen%0d_cyc%0d", e.scen, e.idx), act[0], e.v);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check(1, $sformatf("scen%0d_cyc%0d", e.scen, e.idx), act[1], e.v);
        end
        if (q2.size() > 0) begin
            e = q2.pop_front();
            check(2, $sformatf("scen%0d_cyc%0d", e.scen, e.idx), act[2], e.v);
        end
    end

    task automatic start(input opcode_t op, input logic z);
        @(posedge clock);
        #1;
        n_reset = 1'b0;
        opcode  = op;
        z_flag  = z;
        scen++;
        for (int d = 0; d < 3; d++) begin
            pcnt[d] = 0;
            push(d, V_DEF);
        end
        @(posedge clock);
        #1;
        n_reset = 1'b1;
    endtask

    task automatic drain();
        int budget = 0;
        while ((q0.size() + q1.size() + q2.size()) > 0 && budget < 400) begin
            @(negedge clock);
            budget++;
        end
        if ((q0.size() + q1.size() + q2.size()) > 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout scen%0d pending=%0d required=0", scen,
                     q0.size() + q1.size() + q2.size());
            q0.delete();
            q1.delete();
            q2.delete();
        end
    endtask

    task automatic run_one(input opcode_t op, input logic z, input int n_instr);
        start(op, z);
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < n_instr; i++) push_instr(d, op, z);
            if (op != OP_HALT) push(d, V_IFETCH);
        end
        drain();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        run_one(OP_LOAD,  1'b0, 2);
        run_one(OP_STORE, 1'b0, 1);
        run_one(OP_ADD,   1'b0, 1);
        run_one(OP_SUB,   1'b1, 1);
        run_one(OP_XOR,   1'b0, 1);
        run_one(OP_BRA,   1'b1, 1);
        run_one(OP_BNE,   1'b0, 1);
        run_one(OP_BNE,   1'b1, 1);
        run_one(OP_HALT,  1'b0, 1);

        // Async reset during the second EXEC cycle of the MEM_WAIT=3 instance.
        start(OP_LOAD, 1'b0);
        push(2, V_IFETCH);
        for (int k = 0; k < 3; k++) push(2, M_CS | M_MDRB | M_RNW);
        push(2, M_CS | M_MDRB | M_RNW | M_LIR);
        push(2, M_ADB | M_LMAR | M_RNW);
        push(2, M_CS | M_MDRB | M_RNW);
        push(2, M_CS | M_MDRB | M_RNW);
        repeat (8) @(negedge clock);
        #1;
        n_reset = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) check(d, "async_reset_immediate", act[d], V_DEF);
        push(2, V_DEF);
        push(2, V_DEF);
        drain();
        @(posedge clock);
        #1;
        n_reset = 1'b1;
        for (int d = 0; d < 3; d++) begin
            push(d, V_IFETCH);
            push(d, M_CS | M_MDRB | M_RNW | ((d == 0) ? M_LIR : 15'h0));
        end
        drain();

        for (int c = 0; c < 500; c++) begin
            @(posedge clock);
            #1;
            opcode = 3'($urandom_range(0, 6));
            z_flag = 1'($urandom_range(0, 1));
            @(negedge clock);
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (!$onehot0({act[d][14], act[d][10], act[d][8], act[d][4]})) begin
                    failures++;
                    $display("FAIL bus_exclusive dut%0d cycle%0d got=%h required=onehot0", d, c,
                             act[d]);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
